// File: rtl/ad9226_capture_ctrl_pkg.sv
// rtl/ad9226_capture_ctrl_pkg.sv - shared types, constants and helpers for the AD9226 capture sequencer
package ad9226_pkg;

    localparam int NUM_CH              = 4;
    localparam int CH_ID_WIDTH         = 2;
    localparam int ADC_DATA_WIDTH_DEF  = 12;
    localparam int AXIS_DATA_WIDTH_DEF = 16;
    localparam int DIV_WIDTH_DEF       = 16;
    localparam int FRAME_WIDTH_DEF     = 16;

    // An empty channel mask would never produce a beat, so it falls back to channel 0
    localparam logic [NUM_CH-1:0] MASK_DEFAULT = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [NUM_CH-1:0] norm_mask(input logic [NUM_CH-1:0] m);
        return (m == '0) ? MASK_DEFAULT : m;
    endfunction

    // Index of the lowest set bit; the serializer always emits that channel next
    function automatic logic [CH_ID_WIDTH-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
        logic [CH_ID_WIDTH-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = CH_ID_WIDTH'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/ad9226_capture_ctrl_if.sv
// rtl/ad9226_capture_ctrl_if.sv - sample stream bundle between the sequencer and the DMA/FIFO sink
interface ad9226_capture_ctrl_if
    import ad9226_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH_DEF
) ();
    logic [DATA_WIDTH-1:0]  tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic [CH_ID_WIDTH-1:0] tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/ad9226_sclk_gen.sv
// rtl/ad9226_sclk_gen.sv - half-period divider producing the ADC sample clock
module ad9226_sclk_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 sclk
);
    logic [DIV_WIDTH-1:0] cnt;

    // Count 0..div-1 and toggle on wrap; parked high with the counter cleared when disabled or reloaded
    always_ff @(posedge clk) begin
        if (rst || load || !en) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (cnt == div - DIV_WIDTH'(1)) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + DIV_WIDTH'(1);
        end
    end
endmodule

// File: rtl/ad9226_capture_ctrl.sv
// rtl/ad9226_capture_ctrl.sv - AD9226 capture sequencer: sample clock, set counting, channel serializer
module ad9226_capture_ctrl
    import ad9226_pkg::*;
#(
    parameter int ADC_DATA_WIDTH  = ADC_DATA_WIDTH_DEF,
    parameter int AXIS_DATA_WIDTH = AXIS_DATA_WIDTH_DEF,
    parameter int DIV_WIDTH       = DIV_WIDTH_DEF,
    parameter int FRAME_WIDTH     = FRAME_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [DIV_WIDTH-1:0]      cfg_div,
    input  logic [FRAME_WIDTH-1:0]    cfg_frame_len,
    input  logic [NUM_CH-1:0]         cfg_ch_mask,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic                      adc_clk_sample,
    input  logic                      adc_eoc,
    input  logic [ADC_DATA_WIDTH-1:0] adc_data0,
    input  logic [ADC_DATA_WIDTH-1:0] adc_data1,
    input  logic [ADC_DATA_WIDTH-1:0] adc_data2,
    input  logic [ADC_DATA_WIDTH-1:0] adc_data3,
    ad9226_capture_ctrl_if.master     m_axis
);
    state_t                    state, state_nxt;
    logic                      eoc_q, eoc_q2, eoc_rise;
    logic [DIV_WIDTH-1:0]      div_l;
    logic [FRAME_WIDTH-1:0]    frame_len_l, set_cnt, cnt_inc;
    logic [NUM_CH-1:0]         mask_l, pending, ch_onehot;
    logic [ADC_DATA_WIDTH-1:0] hold [NUM_CH];
    logic                      last_set;
    logic                      start_ok, capture, drop, frame_hit, tvalid, beat_fire;
    logic [CH_ID_WIDTH-1:0]    ch;

    assign start_ok  = (state == ST_IDLE) && start;
    assign eoc_rise  = eoc_q && !eoc_q2;
    assign capture   = (state == ST_RUN) && eoc_rise && (pending == '0);
    assign drop      = (state == ST_RUN) && eoc_rise && (pending != '0);
    // Saturating increment keeps a long continuous run from wrapping back onto frame_len
    assign cnt_inc   = (set_cnt == '1) ? set_cnt : set_cnt + FRAME_WIDTH'(1);
    assign frame_hit = capture && (frame_len_l != '0) && (cnt_inc == frame_len_l);

    assign ch        = lowest_ch(pending);
    assign ch_onehot = NUM_CH'(1) << ch;
    assign tvalid    = (state != ST_IDLE) && (pending != '0);
    assign beat_fire = tvalid && m_axis.tready;

    assign busy            = (state != ST_IDLE);
    assign m_axis.tvalid   = tvalid;
    assign m_axis.tdata    = tvalid ? AXIS_DATA_WIDTH'(hold[ch]) : '0;
    assign m_axis.tuser    = tvalid ? ch : '0;
    // Final beat of the final set: exactly one pending bit left
    assign m_axis.tlast    = tvalid && last_set && ((pending & (pending - NUM_CH'(1))) == '0);

    // End-of-conversion synchronizer and edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            eoc_q  <= 1'b0;
            eoc_q2 <= 1'b0;
        end else begin
            eoc_q  <= adc_eoc;
            eoc_q2 <= eoc_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state and the done pulse
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (stop || frame_hit) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pending == '0) begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Config latch, set capture/drop, pending-channel bookkeeping and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            div_l       <= '0;
            frame_len_l <= '0;
            mask_l      <= '0;
            set_cnt     <= '0;
            pending     <= '0;
            last_set    <= 1'b0;
            overflow    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
        end else if (start_ok) begin
            div_l       <= (cfg_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_div;
            frame_len_l <= cfg_frame_len;
            mask_l      <= norm_mask(cfg_ch_mask);
            set_cnt     <= '0;
            pending     <= '0;
            last_set    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (capture) begin
                hold[0]  <= adc_data0;
                hold[1]  <= adc_data1;
                hold[2]  <= adc_data2;
                hold[3]  <= adc_data3;
                pending  <= mask_l;
                set_cnt  <= cnt_inc;
                last_set <= frame_hit || stop;
            end else begin
                if (beat_fire) pending <= pending & ~ch_onehot;
                // A stop without a new set marks whatever is still pending as the final set
                if ((state == ST_RUN) && stop) last_set <= 1'b1;
            end
            if (drop) overflow <= 1'b1;
        end
    end

    ad9226_sclk_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_RUN),
        .load (start_ok),
        .div  (div_l),
        .sclk (adc_clk_sample)
    );
endmodule

// File: tb/tb_ad9226_capture_ctrl.sv
// tb/tb_ad9226_capture_ctrl.sv - randomized scoreboard bench for the AD9226 capture sequencer
module tb_ad9226_capture_ctrl;
    import ad9226_pkg::*;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  u;
        logic        l;
    } beat_t;

    logic        clk, rst, start, stop;
    logic [15:0] cfg_div, cfg_frame_len;
    logic [3:0]  cfg_ch_mask;
    logic        busy, done, overflow, adc_clk_sample, adc_eoc;
    logic [11:0] adc_data0, adc_data1, adc_data2, adc_data3;

    ad9226_capture_ctrl_if #(.DATA_WIDTH(16)) m_axis ();

    ad9226_capture_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .cfg_div        (cfg_div),
        .cfg_frame_len  (cfg_frame_len),
        .cfg_ch_mask    (cfg_ch_mask),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .adc_clk_sample (adc_clk_sample),
        .adc_eoc        (adc_eoc),
        .adc_data0      (adc_data0),
        .adc_data1      (adc_data1),
        .adc_data2      (adc_data2),
        .adc_data3      (adc_data3),
        .m_axis         (m_axis)
    );

    int    checks = 0, errors = 0;
    beat_t exp_q[$];
    int    beats_seen = 0;
    int    max_sets = 0, stop_at = 0, offered = 0, ready_mode = 0;
    bit    force_data = 0, stop_now = 0, stop_after_eoc = 0;
    logic  [3:0] mdl_mask = 4'h1;
    logic  sclk_prev = 1'b1;
    logic  [11:0] d [4];
    int    hi;
    bit    prev_hold = 0;
    beat_t prev_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Sink readiness pattern selected by the running test
    initial begin
        m_axis.tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       m_axis.tready = 1'b1;
                1:       m_axis.tready = ~m_axis.tready;
                2:       m_axis.tready = 1'($urandom);
                default: m_axis.tready = 1'b0;
            endcase
        end
    end

    // Capture-block model: new data and eoc on each sample-clock rise; predicts the beats of accepted sets
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stop) stop = 1'b0;
            if (stop_now || stop_after_eoc) begin
                stop = 1'b1;
                stop_now = 0;
                stop_after_eoc = 0;
            end
            if (busy !== 1'b1) offered = 0;
            if (adc_clk_sample === 1'b1 && sclk_prev === 1'b0) begin
                for (int i = 0; i < 4; i++) d[i] = 12'($urandom);
                if (force_data) begin
                    d[0] = 12'h000; d[1] = 12'hABC; d[2] = 12'h000; d[3] = 12'h123;
                end
                adc_data0 = d[0]; adc_data1 = d[1]; adc_data2 = d[2]; adc_data3 = d[3];
                adc_eoc = 1'b1;
                if (rst === 1'b0 && busy === 1'b1 && offered < max_sets) begin
                    offered++;
                    hi = 0;
                    for (int c = 0; c < 4; c++) if (mdl_mask[c]) hi = c;
                    for (int c = 0; c < 4; c++) begin
                        if (mdl_mask[c]) begin
                            beat_t b;
                            b.d = 16'(d[c]);
                            b.u = 2'(c);
                            b.l = (offered == max_sets) && (c == hi);
                            exp_q.push_back(b);
                        end
                    end
                    if (offered == stop_at) stop_after_eoc = 1;
                end
            end else if (adc_clk_sample === 1'b0) begin
                adc_eoc = 1'b0;
            end
            sclk_prev = adc_clk_sample;
        end
    end

    // Monitor: score every handshake and hold outputs steady under backpressure
    initial begin
        forever begin
            @(negedge clk);
            if (prev_hold) begin
                check("hold_tvalid", m_axis.tvalid, 1);
                check("hold_tdata", m_axis.tdata, prev_b.d);
                check("hold_tuser", m_axis.tuser, prev_b.u);
                check("hold_tlast", m_axis.tlast, prev_b.l);
            end
            if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
                beats_seen++;
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("tdata", m_axis.tdata, e.d);
                    check("tuser", m_axis.tuser, e.u);
                    check("tlast", m_axis.tlast, e.l);
                end
            end
            prev_hold = (m_axis.tvalid === 1'b1) && (m_axis.tready === 1'b0) && (rst === 1'b0);
            prev_b.d = m_axis.tdata;
            prev_b.u = m_axis.tuser;
            prev_b.l = m_axis.tlast;
            if (rst === 1'b1) begin
                exp_q.delete();
                prev_hold = 0;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [15:0] div, input logic [3:0] mask,
                             input logic [15:0] flen, input int nsets, input int stp,
                             input int rmode, input int hold);
        int cyc, rises, r0, r1, dn, b0, p_exp;
        logic sp;
        bit tmo;
        cfg_div = div; cfg_frame_len = flen; cfg_ch_mask = mask;
        mdl_mask = (mask == 4'h0) ? 4'h1 : mask;
        max_sets = nsets; stop_at = stp;
        ready_mode = (hold > 0) ? 3 : rmode;
        p_exp = 2 * ((div < 16'd2) ? 2 : int'(div));
        b0 = beats_seen;
        pulse_start();
        check({tag, "_busy_on"}, busy, 1);
        if (hold == 0) check({tag, "_ovf_cleared"}, overflow, 0);
        cfg_div = 16'($urandom); cfg_frame_len = 16'($urandom); cfg_ch_mask = 4'($urandom);
        sp = adc_clk_sample; rises = 0; r0 = 0; r1 = 0; dn = 0; cyc = 0; tmo = 1;
        while (cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == 5);
            if (done) dn++;
            if (adc_clk_sample && !sp) begin
                rises++;
                if (rises == 1) r0 = cyc;
                if (rises == 2) r1 = cyc;
            end
            sp = adc_clk_sample;
            if (hold > 0 && cyc == hold) begin
                check({tag, "_ovf_set"}, overflow, 1);
                stop_now = 1;
            end
            if (hold > 0 && cyc == hold + 3) ready_mode = 0;
            if (!busy) begin
                tmo = 0;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_timeout"}, tmo, 0);
        check({tag, "_done_once"}, dn, 1);
        if (rises >= 2 && nsets >= 2) check({tag, "_sclk_period"}, r1 - r0, p_exp);
        @(posedge clk); #1;
        check({tag, "_done_low"}, done, 0);
        check({tag, "_busy_off"}, busy, 0);
        check({tag, "_sclk_idle"}, adc_clk_sample, 1);
        check({tag, "_beat_count"}, beats_seen - b0, nsets * $countones(mdl_mask));
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        if (hold > 0) check({tag, "_ovf_sticky"}, overflow, 1);
    endtask

    initial begin
        int cyc, fl;
        rst = 1'b1; start = 1'b0; stop = 1'b0; adc_eoc = 1'b0;
        cfg_div = 16'd0; cfg_frame_len = 16'd0; cfg_ch_mask = 4'h0;
        adc_data0 = '0; adc_data1 = '0; adc_data2 = '0; adc_data3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_sclk", adc_clk_sample, 1);
        check("rst_tvalid", m_axis.tvalid, 0);
        check("rst_tdata", m_axis.tdata, 0);
        check("rst_tuser", m_axis.tuser, 0);
        check("rst_tlast", m_axis.tlast, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run_frame("div", 16'd4, 4'hF, 16'd2, 2, 0, 0, 0);
        force_data = 1;
        run_frame("mask", 16'd4, 4'b1010, 16'd1, 1, 0, 1, 0);
        force_data = 0;
        run_frame("ovf", 16'd2, 4'hF, 16'd0, 1, 0, 0, 40);
        run_frame("cont_stop", 16'd4, 4'hF, 16'd0, 5, 5, 0, 0);

        cfg_div = 16'd4; cfg_frame_len = 16'd2; cfg_ch_mask = 4'hF;
        mdl_mask = 4'hF; max_sets = 2; stop_at = 0; ready_mode = 0;
        fl = beats_seen;
        pulse_start();
        cyc = 0;
        while (cyc < 500 && !((beats_seen - fl) >= 1 && m_axis.tvalid === 1'b1)) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("midrst_wait", cyc < 500, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_tvalid", m_axis.tvalid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sclk", adc_clk_sample, 1);
        check("midrst_overflow", overflow, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        run_frame("post_rst", 16'd3, 4'h5, 16'd2, 2, 0, 0, 0);

        run_frame("degen", 16'd0, 4'h0, 16'd3, 3, 0, 0, 0);

        for (int k = 0; k < 6; k++) begin
            logic [15:0] rd;
            logic [3:0]  rm;
            int          ns;
            rd = 16'($urandom_range(3, 6));
            rm = 4'($urandom_range(1, 15));
            ns = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 0)
                run_frame("rnd_fixed", rd, rm, 16'(ns), ns, 0, (ns == 1) ? 2 : 0, 0);
            else
                run_frame("rnd_stop", rd, rm, 16'd0, ns, ns, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
